execution_issue_unit: RTL and testbench

//   Issue side of the execution-unit command/result interface. Buffers decoded

---
 rtl/execution_issue_unit.sv | 174 +++++++++++++++++
 tb/tb_execution_issue_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_issue_unit.sv
// Issue side of the execution-unit interface: in-order command FIFO,
// one command in flight, captured result offered to writeback.
`timescale 1ns/1ps

package execution_pkg;
  typedef struct packed {
    logic [3:0]  alu_ctl;
    logic [31:0] op1;
    logic [31:0] op2;
  } execution_command_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  outcome;
    logic        mtc0;
  } execution_result_t;
endpackage

module execution_issue_unit
  import execution_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_valid,
  input  execution_command_t i_command,
  output logic               o_ready,
  output logic               o_exec_valid,
  output execution_command_t o_exec_command,
  input  logic               i_exec_done,
  input  execution_result_t  i_exec_result,
  output logic               o_wb_valid,
  output execution_result_t  o_wb_result,
  input  logic               i_wb_ready,
  output logic               o_timeout,
  output logic               o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  execution_command_t mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [1:0]         state;
  logic [1:0]         state_nxt;
  execution_command_t issue_q;
  execution_result_t  result_q;
  logic               wb_valid_q;
  logic [TW-1:0]      wd_cnt;
  logic               timeout_q;

  logic push;
  logic pop;
  logic stall;
  logic done;
  logic wb_hs;
  logic empty;
  logic capture;

  assign empty   = (count == '0);
  assign o_ready = (count != CW'(DEPTH)) && !i_flush;
  assign push    = i_valid && o_ready;
  assign stall   = wb_valid_q && !i_wb_ready;
  assign o_exec_valid = ((state == ISSUE) && !stall)
                     || (state == DRAIN);
  assign done    = o_exec_valid && i_exec_done;
  assign wb_hs   = wb_valid_q && i_wb_ready;
  assign capture = done && (state == ISSUE) && !i_flush;

  assign o_exec_command = issue_q;
  assign o_wb_valid     = wb_valid_q;
  assign o_wb_result    = result_q;
  assign o_timeout      = timeout_q;
  assign o_busy = !empty || (state != IDLE) || wb_valid_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !i_flush) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (i_flush) begin
          state_nxt = done ? IDLE : DRAIN;
        end else if (done) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_command;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      issue_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop)
        issue_q <= mem[rd_ptr];
      else if (state_nxt == IDLE)
        issue_q <= '0;
    end
  end

  // a refill on the handshake cycle wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      result_q   <= '0;
    end else if (i_flush) begin
      wb_valid_q <= 1'b0;
      result_q   <= '0;
    end else if (capture) begin
      wb_valid_q <= 1'b1;
      result_q   <= i_exec_result;
    end else if (wb_hs) begin
      wb_valid_q <= 1'b0;
      result_q   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (done)
        wd_cnt <= '0;
      else if (o_exec_valid && wd_cnt != TW'(TIMEOUT))
        wd_cnt <= wd_cnt + 1'b1;
      if (o_exec_valid && !i_exec_done
          && wd_cnt == TW'(TIMEOUT - 1))
        timeout_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_execution_issue_unit.sv
// Scoreboard bench for execution_issue_unit: directed vectors,
// expected results queued at issue and popped by a writeback monitor.
`timescale 1ns/1ps

module tb_execution_issue_unit;
  import execution_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic               clk;
  logic               rst;
  logic               i_flush;
  logic               i_valid;
  execution_command_t i_command;
  logic               o_ready;
  logic               o_exec_valid;
  execution_command_t o_exec_command;
  logic               i_exec_done;
  execution_result_t  i_exec_result;
  logic               o_wb_valid;
  execution_result_t  o_wb_result;
  logic               i_wb_ready;
  logic               o_timeout;
  logic               o_busy;

  logic done_en;
  int   checks;
  int   failures;
  execution_result_t exp_q [$];

  execution_issue_unit #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .i_command     (i_command),
    .o_ready       (o_ready),
    .o_exec_valid  (o_exec_valid),
    .o_exec_command(o_exec_command),
    .i_exec_done   (i_exec_done),
    .i_exec_result (i_exec_result),
    .o_wb_valid    (o_wb_valid),
    .o_wb_result   (o_wb_result),
    .i_wb_ready    (i_wb_ready),
    .o_timeout     (o_timeout),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural execution unit: 0 add, 1 sub, 2 and, 3 or
  always_comb begin
    i_exec_result = '0;
    case (o_exec_command.alu_ctl)
      4'd0: i_exec_result.data = o_exec_command.op1 + o_exec_command.op2;
      4'd1: i_exec_result.data = o_exec_command.op1 - o_exec_command.op2;
      4'd2: i_exec_result.data = o_exec_command.op1 & o_exec_command.op2;
      4'd3: i_exec_result.data = o_exec_command.op1 | o_exec_command.op2;
      default: i_exec_result.data = '0;
    endcase
  end
  assign i_exec_done = done_en;

  function automatic execution_command_t mk_cmd(
    input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b);
    execution_command_t c;
    c.alu_ctl = alu;
    c.op1     = a;
    c.op2     = b;
    return c;
  endfunction

  function automatic execution_result_t mk_res(input logic [31:0] d);
    execution_result_t r;
    r.data    = d;
    r.outcome = 2'b00;
    r.mtc0    = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one command for one cycle; expects the slot to be open
  task automatic push(input execution_command_t c,
                      input logic [31:0] d, input bit keep);
    chk("push_ready", o_ready, 1'b1);
    i_valid   = 1'b1;
    i_command = c;
    if (keep) exp_q.push_back(mk_res(d));
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // accept at cycle 0, exec at 2, writeback at 3, idle at 4
  task automatic latency(input execution_command_t c, input logic [31:0] d);
    chk("lat_ready", o_ready, 1'b1);
    i_valid   = 1'b1;
    i_command = c;
    exp_q.push_back(mk_res(d));
    @(negedge clk);
    chk("lat_c0_exec", o_exec_valid, 1'b0);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_exec", o_exec_valid, 1'b0);
    @(negedge clk);
    chk("lat_c2_exec", o_exec_valid, 1'b1);
    chk("lat_c2_cmd", o_exec_command, c);
    @(negedge clk);
    chk("lat_c3_wb", o_wb_valid, 1'b1);
    @(negedge clk);
    chk("lat_c4_busy", o_busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && o_wb_valid) begin
      if (i_wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", o_wb_result, 35'h0);
          chk("wb_unexpected_valid", o_wb_valid, 1'b0);
        end else begin
          chk("wb_result", o_wb_result, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        chk("wb_hold", o_wb_result, exp_q[0]);
        chk("wb_stall_exec", o_exec_valid, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    i_flush    = 1'b0;
    i_valid    = 1'b0;
    i_command  = '0;
    i_wb_ready = 1'b1;
    done_en    = 1'b1;
    repeat (3) step();
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_exec", o_exec_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    rst = 1'b0;
    step();

    // combinational ADD 5+3
    latency(mk_cmd(4'd0, 32'd5, 32'd3), 32'd8);
    wait_drain();

    // fill the FIFO behind a blocked unit
    done_en = 1'b0;
    push(mk_cmd(4'd0, 32'd1, 32'd2), 32'd3, 1'b1);
    push(mk_cmd(4'd1, 32'd10, 32'd4), 32'd6, 1'b1);
    push(mk_cmd(4'd2, 32'd12, 32'd10), 32'd8, 1'b1);
    push(mk_cmd(4'd3, 32'd1, 32'd4), 32'd5, 1'b1);
    push(mk_cmd(4'd0, 32'd100, 32'd23), 32'd123, 1'b1);
    chk("full_ready", o_ready, 1'b0);
    chk("full_held_cmd", o_exec_command.op1, 32'd1);
    done_en = 1'b1;
    step();
    chk("full_reopen", o_ready, 1'b1);
    wait_drain();

    // writeback back-pressure
    i_wb_ready = 1'b0;
    push(mk_cmd(4'd0, 32'd7, 32'd7), 32'd14, 1'b1);
    push(mk_cmd(4'd1, 32'd9, 32'd2), 32'd7, 1'b1);
    repeat (3) step();
    chk("bp_wb_valid", o_wb_valid, 1'b1);
    i_wb_ready = 1'b1;
    wait_drain();

    // flush during a 4-cycle operation
    done_en = 1'b0;
    push(mk_cmd(4'd0, 32'd1, 32'd1), 32'd0, 1'b0);
    push(mk_cmd(4'd0, 32'd2, 32'd2), 32'd0, 1'b0);
    push(mk_cmd(4'd0, 32'd3, 32'd3), 32'd0, 1'b0);
    i_flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", o_ready, 1'b0);
    chk("fl_exec", o_exec_valid, 1'b1);
    step();
    i_flush = 1'b0;
    @(negedge clk);
    chk("drain_exec", o_exec_valid, 1'b1);
    chk("drain_cmd", o_exec_command.op1, 32'd1);
    step();
    done_en = 1'b1;
    @(negedge clk);
    chk("drain_wb", o_wb_valid, 1'b0);
    step();
    done_en = 1'b0;
    @(negedge clk);
    chk("post_drain_wb", o_wb_valid, 1'b0);
    chk("post_drain_exec", o_exec_valid, 1'b0);
    chk("post_drain_busy", o_busy, 1'b0);
    step();
    chk("post_drain_exec2", o_exec_valid, 1'b0);
    chk("pre_wd_timeout", o_timeout, 1'b0);

    // reset in the middle of ISSUE with a result pending
    done_en    = 1'b1;
    i_wb_ready = 1'b0;
    push(mk_cmd(4'd0, 32'd2, 32'd2), 32'd4, 1'b1);
    push(mk_cmd(4'd0, 32'd3, 32'd3), 32'd6, 1'b1);
    step();
    step();
    chk("mid_wb_valid", o_wb_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("ar_ready", o_ready, 1'b1);
    chk("ar_exec", o_exec_valid, 1'b0);
    chk("ar_cmd", o_exec_command, 68'h0);
    chk("ar_wb_valid", o_wb_valid, 1'b0);
    chk("ar_wb_result", o_wb_result, 35'h0);
    chk("ar_timeout", o_timeout, 1'b0);
    chk("ar_busy", o_busy, 1'b0);
    step();
    rst = 1'b0;
    i_wb_ready = 1'b1;
    latency(mk_cmd(4'd3, 32'hF0, 32'h0F), 32'hFF);
    wait_drain();

    // watchdog
    done_en = 1'b0;
    push(mk_cmd(4'd1, 32'd50, 32'd8), 32'd42, 1'b1);
    repeat (8) step();
    @(negedge clk);
    chk("wd_before", o_timeout, 1'b0);
    step();
    @(negedge clk);
    chk("wd_rise", o_timeout, 1'b1);
    step();
    done_en = 1'b1;
    step();
    done_en = 1'b0;
    @(negedge clk);
    chk("wd_after_done", o_timeout, 1'b1);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge clk);
    chk("wd_after_flush", o_timeout, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
